// File: rtl/control_pipe_if.sv
// IF/ID-side instruction bundle and ID/EX control outputs
// of the main control unit.
interface control_pipe_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
);
  logic                  valid_i;
  logic [6:0]            opcode_i;
  logic [REG_ADDR_W-1:0] rd_i;
  logic [REG_ADDR_W-1:0] rs1_i;
  logic [REG_ADDR_W-1:0] rs2_i;
  logic                  flush_i;
  logic                  hold_i;
  logic                  stall_o;
  logic                  ex_valid_o;
  logic [ALUOP_W-1:0]    ex_aluop_o;
  logic                  ex_alu_src_o;
  logic                  ex_alu_a_pc_o;
  logic                  ex_memread_o;
  logic                  ex_memwrite_o;
  logic                  ex_regwrite_o;
  logic                  ex_mem_to_reg_o;
  logic                  ex_branch_o;
  logic                  ex_jump_o;
  logic [REG_ADDR_W-1:0] ex_rd_o;
  logic                  ex_illegal_o;

  modport master (
    output valid_i, opcode_i, rd_i,
    output rs1_i, rs2_i, flush_i, hold_i,
    input  stall_o, ex_valid_o, ex_aluop_o,
    input  ex_alu_src_o, ex_alu_a_pc_o,
    input  ex_memread_o, ex_memwrite_o,
    input  ex_regwrite_o, ex_mem_to_reg_o,
    input  ex_branch_o, ex_jump_o,
    input  ex_rd_o, ex_illegal_o
  );

  modport slave (
    input  valid_i, opcode_i, rd_i,
    input  rs1_i, rs2_i, flush_i, hold_i,
    output stall_o, ex_valid_o, ex_aluop_o,
    output ex_alu_src_o, ex_alu_a_pc_o,
    output ex_memread_o, ex_memwrite_o,
    output ex_regwrite_o, ex_mem_to_reg_o,
    output ex_branch_o, ex_jump_o,
    output ex_rd_o, ex_illegal_o
  );
endinterface

// File: rtl/control_pipe.sv
// RV32I main control: opcode decode, load-use stall,
// flush/hold handling and the ID/EX control register.
module control_pipe #(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int ALUOP_W        = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  control_pipe_if.slave bus
);

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               mem_to_reg;
    logic               branch;
    logic               jump;
    logic               alu_src;
    logic               alu_a_pc;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
  } ctrl_t;

  localparam logic LUS = (LOAD_USE_STALL != 0);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  ctrl_t                 w_dec;
  logic                  w_use_rs1;
  logic                  w_use_rs2;
  logic                  w_hit1;
  logic                  w_hit2;
  logic                  w_hazard;

  ctrl_t                 r_ctrl;
  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rd;

  always_comb begin
    w_dec     = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    unique case (bus.opcode_i)
      OP_R: begin
        w_dec.regwrite = 1'b1;
        w_dec.alu_src  = 1'b1;
        w_dec.aluop    = ALUOP_W'(2'b10);
        w_use_rs1      = 1'b1;
        w_use_rs2      = 1'b1;
      end
      OP_I: begin
        w_dec.regwrite = 1'b1;
        w_dec.aluop    = ALUOP_W'(2'b10);
        w_use_rs1      = 1'b1;
      end
      OP_LD: begin
        w_dec.regwrite   = 1'b1;
        w_dec.memread    = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_use_rs1        = 1'b1;
      end
      OP_ST: begin
        w_dec.memwrite = 1'b1;
        w_use_rs1      = 1'b1;
        w_use_rs2      = 1'b1;
      end
      OP_BR: begin
        w_dec.branch  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.aluop   = ALUOP_W'(2'b01);
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
      end
      OP_JAL: begin
        w_dec.regwrite = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.alu_a_pc = 1'b1;
      end
      OP_JALR: begin
        w_dec.regwrite = 1'b1;
        w_dec.jump     = 1'b1;
        w_use_rs1      = 1'b1;
      end
      OP_LUI: begin
        w_dec.regwrite = 1'b1;
        w_dec.aluop    = ALUOP_W'(2'b11);
      end
      OP_AUIPC: begin
        w_dec.regwrite = 1'b1;
        w_dec.alu_a_pc = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  // x0 is never a real producer, so it cannot cause a stall
  assign w_hit1 = w_use_rs1 && (bus.rs1_i == r_rd);
  assign w_hit2 = w_use_rs2 && (bus.rs2_i == r_rd);

  assign w_hazard = LUS && bus.valid_i && r_valid
                 && r_ctrl.memread && (r_rd != '0)
                 && (w_hit1 || w_hit2);

  assign bus.stall_o = (w_hazard || bus.hold_i)
                    && !bus.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end else if (bus.flush_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end else if (bus.hold_i) begin
      r_valid <= r_valid;
    end else if (w_hazard || !bus.valid_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end else begin
      r_valid <= 1'b1;
      r_ctrl  <= w_dec;
      r_rd    <= bus.rd_i;
    end
  end

  assign bus.ex_valid_o      = r_valid;
  assign bus.ex_aluop_o      = r_ctrl.aluop;
  assign bus.ex_alu_src_o    = r_ctrl.alu_src;
  assign bus.ex_alu_a_pc_o   = r_ctrl.alu_a_pc;
  assign bus.ex_memread_o    = r_ctrl.memread;
  assign bus.ex_memwrite_o   = r_ctrl.memwrite;
  assign bus.ex_regwrite_o   = r_ctrl.regwrite;
  assign bus.ex_mem_to_reg_o = r_ctrl.mem_to_reg;
  assign bus.ex_branch_o     = r_ctrl.branch;
  assign bus.ex_jump_o       = r_ctrl.jump;
  assign bus.ex_rd_o         = r_rd;
  assign bus.ex_illegal_o    = r_ctrl.illegal;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: decode table, load-use,
// hold, flush and reset behaviour.
module tb_control_pipe;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic clk;
  logic rst;
  logic clk_en;
  int   n_chk;
  int   n_fail;

  control_pipe_if #(.REG_ADDR_W(5), .ALUOP_W(2)) bus ();
  control_pipe_if #(.REG_ADDR_W(5), .ALUOP_W(2)) bus0 ();

  control_pipe #(
    .REG_ADDR_W(5), .LOAD_USE_STALL(1), .ALUOP_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  control_pipe #(
    .REG_ADDR_W(5), .LOAD_USE_STALL(0), .ALUOP_W(2)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );

  assign bus0.valid_i  = bus.valid_i;
  assign bus0.opcode_i = bus.opcode_i;
  assign bus0.rd_i     = bus.rd_i;
  assign bus0.rs1_i    = bus.rs1_i;
  assign bus0.rs2_i    = bus.rs2_i;
  assign bus0.flush_i  = bus.flush_i;
  assign bus0.hold_i   = bus.hold_i;

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {valid, aluop, alu_src, a_pc, memread, memwrite,
  //  regwrite, mem_to_reg, branch, jump, illegal}
  function automatic logic [11:0] mk(
    input logic v,  input logic rw, input logic mr,
    input logic mw, input logic m2r, input logic br,
    input logic j,  input logic as, input logic ap,
    input logic [1:0] op, input logic ill);
    return {v, op, as, ap, mr, mw, rw, m2r, br, j, ill};
  endfunction

  function automatic logic [11:0] exv();
    return {bus.ex_valid_o, bus.ex_aluop_o,
            bus.ex_alu_src_o, bus.ex_alu_a_pc_o,
            bus.ex_memread_o, bus.ex_memwrite_o,
            bus.ex_regwrite_o, bus.ex_mem_to_reg_o,
            bus.ex_branch_o, bus.ex_jump_o,
            bus.ex_illegal_o};
  endfunction

  task automatic drive(input logic v, input logic [6:0] op,
                       input logic [4:0] rd,
                       input logic [4:0] rs1,
                       input logic [4:0] rs2);
    bus.valid_i  = v;
    bus.opcode_i = op;
    bus.rd_i     = rd;
    bus.rs1_i    = rs1;
    bus.rs2_i    = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0]  ops  [9];
  logic [11:0] exps [9];
  logic [11:0] e_r, e_i, e_ld, e_st, e_lui, e_ill;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clk_en = 1'b0;
    rst    = 1'b1;
    bus.flush_i = 1'b0;
    bus.hold_i  = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);

    e_r   = mk(1,1,0,0,0,0,0,1,0,2'b10,0);
    e_i   = mk(1,1,0,0,0,0,0,0,0,2'b10,0);
    e_ld  = mk(1,1,1,0,1,0,0,0,0,2'b00,0);
    e_st  = mk(1,0,0,1,0,0,0,0,0,2'b00,0);
    e_lui = mk(1,1,0,0,0,0,0,0,0,2'b11,0);
    e_ill = mk(1,0,0,0,0,0,0,0,0,2'b00,1);

    ops[0] = OP_R;     exps[0] = e_r;
    ops[1] = OP_I;     exps[1] = e_i;
    ops[2] = OP_LD;    exps[2] = e_ld;
    ops[3] = OP_ST;    exps[3] = e_st;
    ops[4] = OP_BR;
    exps[4] = mk(1,0,0,0,0,1,0,1,0,2'b01,0);
    ops[5] = OP_JAL;
    exps[5] = mk(1,1,0,0,0,0,1,0,1,2'b00,0);
    ops[6] = OP_JALR;
    exps[6] = mk(1,1,0,0,0,0,1,0,0,2'b00,0);
    ops[7] = OP_LUI;   exps[7] = e_lui;
    ops[8] = OP_AUIPC;
    exps[8] = mk(1,1,0,0,0,0,0,0,1,2'b00,0);

    #5;
    chk("rst_ex", {20'd0, exv()}, 32'd0);
    chk("rst_rd", {27'd0, bus.ex_rd_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    rst    = 1'b0;
    clk_en = 1'b1;

    drive(1, OP_R, 5'd3, 5'd1, 5'd2);
    tick();
    chk("r_ex", {20'd0, exv()}, {20'd0, e_r});
    chk("r_rd", {27'd0, bus.ex_rd_o}, 32'd3);

    drive(1, OP_LD, 5'd5, 5'd1, 5'd0);
    tick();
    chk("ld_ex", {20'd0, exv()}, {20'd0, e_ld});
    drive(1, OP_R, 5'd7, 5'd1, 5'd5);
    #1;
    chk("lu_stall", {31'd0, bus.stall_o}, 32'd1);
    chk("lu_nostall_p0", {31'd0, bus0.stall_o}, 32'd0);
    tick();
    chk("lu_bubble", {20'd0, exv()}, 32'd0);
    chk("lu_bub_rd", {27'd0, bus.ex_rd_o}, 32'd0);
    chk("lu_stall2", {31'd0, bus.stall_o}, 32'd0);
    tick();
    chk("lu_issue", {20'd0, exv()}, {20'd0, e_r});
    chk("lu_issue_rd", {27'd0, bus.ex_rd_o}, 32'd7);

    drive(1, OP_LD, 5'd0, 5'd1, 5'd0);
    tick();
    drive(1, OP_R, 5'd8, 5'd0, 5'd0);
    #1;
    chk("x0_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    chk("x0_issue_rd", {27'd0, bus.ex_rd_o}, 32'd8);

    drive(1, OP_LD, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1, OP_LUI, 5'd5, 5'd5, 5'd5);
    #1;
    chk("lui_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    chk("lui_ex", {20'd0, exv()}, {20'd0, e_lui});
    drive(1, OP_LD, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1, OP_I, 5'd6, 5'd6, 5'd5);
    #1;
    chk("i_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    chk("i_ex", {20'd0, exv()}, {20'd0, e_i});

    drive(1, 7'b0000000, 5'd9, 5'd0, 5'd0);
    tick();
    chk("ill_ex", {20'd0, exv()}, {20'd0, e_ill});
    chk("ill_rd", {27'd0, bus.ex_rd_o}, 32'd9);

    drive(1, OP_ST, 5'd4, 5'd1, 5'd2);
    tick();
    chk("st_ex", {20'd0, exv()}, {20'd0, e_st});
    bus.hold_i = 1'b1;
    drive(1, OP_R, 5'd10, 5'd1, 5'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_stall", {31'd0, bus.stall_o}, 32'd1);
      tick();
      chk("hold_ex", {20'd0, exv()}, {20'd0, e_st});
      chk("hold_rd", {27'd0, bus.ex_rd_o}, 32'd4);
    end
    bus.hold_i = 1'b0;
    tick();
    chk("unhold_ex", {20'd0, exv()}, {20'd0, e_r});
    chk("unhold_rd", {27'd0, bus.ex_rd_o}, 32'd10);

    drive(1, OP_LD, 5'd5, 5'd1, 5'd0);
    tick();
    drive(1, OP_R, 5'd12, 5'd5, 5'd1);
    bus.hold_i  = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    chk("fl_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    chk("fl_bubble", {20'd0, exv()}, 32'd0);
    chk("fl_rd", {27'd0, bus.ex_rd_o}, 32'd0);
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;

    for (int k = 0; k < 9; k++) begin
      drive(1, ops[k], 5'(k + 1), 5'd0, 5'd0);
      tick();
      chk($sformatf("dec_%0d", k), {20'd0, exv()},
          {20'd0, exps[k]});
      chk($sformatf("dec_rd_%0d", k),
          {27'd0, bus.ex_rd_o}, 32'(k + 1));
    end

    drive(0, OP_R, 5'd13, 5'd0, 5'd0);
    tick();
    chk("inv_bubble", {20'd0, exv()}, 32'd0);

    drive(1, OP_R, 5'd11, 5'd0, 5'd0);
    tick();
    chk("pre_rst", {20'd0, exv()}, {20'd0, e_r});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {20'd0, exv()}, 32'd0);
    chk("async_rst_rd", {27'd0, bus.ex_rd_o}, 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
